// File: rtl/mispredict_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: captures the oldest mispredicted slot in M,
// issues a one-cycle redirect/flush, then ignores wrong-path resolutions for a shadow window.
module mispredict_recovery_ctrl #(
  parameter int PC_W          = 11,
  parameter int SHADOW_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branchM1,
  input  logic             branchM2,
  input  logic             PredictionM1,
  input  logic             PredictionM2,
  input  logic             branch_taken1,
  input  logic             branch_taken2,
  input  logic [PC_W-1:0]  CorrectedPC1,
  input  logic [PC_W-1:0]  CorrectedPC2,
  input  logic             stallM,
  input  logic             clear_stats,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic             squash_slot2,
  output logic             busy,
  output logic [CNT_W-1:0] mispredict_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SHADOW   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             squash_q, squash_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misp1, misp2, capture;

  always_comb begin
    misp1   = branchM1 & (PredictionM1 != branch_taken1);
    misp2   = branchM2 & (PredictionM2 != branch_taken2);
    capture = (state_q == IDLE) & ~stallM & (misp1 | misp2);

    state_d  = state_q;
    shadow_d = shadow_q;
    pc_d     = pc_q;
    squash_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d  = REDIRECT;
          pc_d     = misp1 ? CorrectedPC1 : CorrectedPC2;
          squash_d = misp1;
        end
      end
      REDIRECT: begin
        state_d  = SHADOW;
        shadow_d = 4'(SHADOW_CYCLES);
      end
      SHADOW: begin
        shadow_d = shadow_q - 4'd1;
        if (shadow_q == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so the redirect appears one cycle after capture.
    flush_d = (state_d == REDIRECT);
    busy_d  = (state_d != IDLE);

    cnt_d = cnt_q;
    if (clear_stats)                  cnt_d = '0;
    else if (capture && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      pc_q     <= '0;
      flush_q  <= 1'b0;
      squash_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      pc_q     <= pc_d;
      flush_q  <= flush_d;
      squash_q <= squash_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign redirect_valid   = flush_q;
  assign flushF           = flush_q;
  assign flushD           = flush_q;
  assign flushE           = flush_q;
  assign squash_slot2     = squash_q;
  assign busy             = busy_q;
  assign redirect_pc      = pc_q;
  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_mispredict_recovery_ctrl.sv
// Self-checking bench for mispredict_recovery_ctrl: directed scenarios plus random traffic
// checked against a busy-countdown reference model.
module tb_mispredict_recovery_ctrl;
  localparam int PC_W = 11;
  localparam int S    = 2;
  localparam int CW   = 16;
  localparam int SCW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b1 = 0, b2 = 0, p1 = 0, p2 = 0, t1 = 0, t2 = 0, stall = 0, clr = 0;
  logic [PC_W-1:0] pc1 = '0, pc2 = '0;

  logic            rv, fF, fD, fE, sq, bz;
  logic [PC_W-1:0] rpc;
  logic [CW-1:0]   cnt;
  logic            s_rv, s_fF, s_fD, s_fE, s_sq, s_bz;
  logic [PC_W-1:0] s_rpc;
  logic [SCW-1:0]  s_cnt;

  int total = 0, bad = 0;

  // Reference model: cycles of busy remaining, last target, last pulse.
  int              m_rem = 0;
  logic            m_pulse = 0, m_sq = 0;
  logic [PC_W-1:0] m_pc = '0;
  int              m_cnt = 0, m_cnts = 0;

  always #5 clk = ~clk;

  mispredict_recovery_ctrl #(.PC_W(PC_W), .SHADOW_CYCLES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .branchM1(b1), .branchM2(b2), .PredictionM1(p1), .PredictionM2(p2),
    .branch_taken1(t1), .branch_taken2(t2), .CorrectedPC1(pc1), .CorrectedPC2(pc2),
    .stallM(stall), .clear_stats(clr), .redirect_valid(rv), .redirect_pc(rpc),
    .flushF(fF), .flushD(fD), .flushE(fE), .squash_slot2(sq), .busy(bz), .mispredict_count(cnt));

  mispredict_recovery_ctrl #(.PC_W(PC_W), .SHADOW_CYCLES(S), .CNT_W(SCW)) dut_sat (
    .clk(clk), .rst(rst), .branchM1(b1), .branchM2(b2), .PredictionM1(p1), .PredictionM2(p2),
    .branch_taken1(t1), .branch_taken2(t2), .CorrectedPC1(pc1), .CorrectedPC2(pc2),
    .stallM(stall), .clear_stats(clr), .redirect_valid(s_rv), .redirect_pc(s_rpc),
    .flushF(s_fF), .flushD(s_fD), .flushE(s_fE), .squash_slot2(s_sq), .busy(s_bz),
    .mispredict_count(s_cnt));

  function automatic logic [32:0] exp_main();
    return {m_pulse, m_pulse, m_pulse, m_pulse, m_pulse & m_sq, m_rem != 0, m_pc, 16'(m_cnt)};
  endfunction
  function automatic logic [32:0] obs_main();
    return {rv, fF, fD, fE, sq, bz, rpc, cnt};
  endfunction
  function automatic logic [19:0] exp_sat();
    return {m_pulse, m_pulse, m_pulse, m_pulse, m_pulse & m_sq, m_rem != 0, m_pc, 3'(m_cnts)};
  endfunction
  function automatic logic [19:0] obs_sat();
    return {s_rv, s_fF, s_fD, s_fE, s_sq, s_bz, s_rpc, s_cnt};
  endfunction

  task automatic model_reset();
    m_rem = 0; m_pulse = 0; m_sq = 0; m_pc = '0; m_cnt = 0; m_cnts = 0;
  endtask

  task automatic tick();
    logic mp1, mp2, cap;
    @(posedge clk);
    mp1 = b1 && (p1 != t1);
    mp2 = b2 && (p2 != t2);
    cap = (m_rem == 0) && !stall && (mp1 || mp2);
    if (cap) begin
      m_pulse = 1; m_sq = mp1; m_pc = mp1 ? pc1 : pc2; m_rem = S + 1;
    end else begin
      m_pulse = 0;
      if (m_rem > 0) m_rem--;
    end
    if (clr) begin m_cnt = 0; m_cnts = 0; end
    else if (cap) begin
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      if (m_cnts < (1 << SCW) - 1) m_cnts++;
    end
    #1;
  endtask

  task automatic quiet();
    b1 = 0; b2 = 0; p1 = 0; p2 = 0; t1 = 0; t2 = 0; stall = 0; clr = 0;
  endtask

  task automatic settle();
    quiet();
    repeat (S + 3) tick();
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (obs_main() !== 33'd0) begin bad++; $display("FAIL reset_main got=%h want=0", obs_main()); end
    total++;
    if (obs_sat() !== 20'd0) begin bad++; $display("FAIL reset_sat got=%h want=0", obs_sat()); end
    rst = 0;
    model_reset();
    tick();
    total++;
    if (obs_main() !== exp_main()) begin bad++; $display("FAIL post_reset got=%h want=%h", obs_main(), exp_main()); end
  endtask

  task automatic test_slot1();
    settle();
    b1 = 1; p1 = 0; t1 = 1; pc1 = 11'h1A0; b2 = 1; p2 = 1; t2 = 1; pc2 = 11'h055;
    tick();
    quiet();
    total++;
    if ({rv, fF, fD, fE, sq, rpc, cnt} !== {5'b11111, 11'h1A0, 16'd1}) begin
      bad++; $display("FAIL slot1_pulse got=%b%b%b%b%b pc=%h cnt=%0d want=11111 pc=1a0 cnt=1", rv, fF, fD, fE, sq, rpc, cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bz, rv} !== {(i < 2), 1'b0} || obs_main() !== exp_main()) begin
        bad++; $display("FAIL slot1_busy[%0d] got=%h want=%h", i, obs_main(), exp_main());
      end
    end
  endtask

  task automatic test_both_slots();
    settle();
    b1 = 1; p1 = 1; t1 = 0; pc1 = 11'h010; b2 = 1; p2 = 0; t2 = 1; pc2 = 11'h020;
    tick();
    quiet();
    total++;
    if ({rv, sq, rpc, cnt} !== {2'b11, 11'h010, 16'd2} || obs_main() !== exp_main()) begin
      bad++; $display("FAIL both_slots got=%h want=%h", obs_main(), exp_main());
    end
  endtask

  task automatic test_slot2_shadow();
    settle();
    b2 = 1; p2 = 1; t2 = 0; pc2 = 11'h7FF;
    tick();
    quiet();
    total++;
    if ({rv, sq, rpc} !== {2'b10, 11'h7FF} || obs_main() !== exp_main()) begin
      bad++; $display("FAIL slot2_pulse got=%h want=%h", obs_main(), exp_main());
    end
    tick();
    b1 = 1; p1 = 0; t1 = 1; pc1 = 11'h333;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (rv !== 1'b0 || obs_main() !== exp_main()) begin
        bad++; $display("FAIL shadow_ignore[%0d] got=%h want=%h", i, obs_main(), exp_main());
      end
    end
    tick();
    quiet();
    total++;
    if ({rv, sq, rpc, cnt} !== {2'b11, 11'h333, 16'd4} || obs_main() !== exp_main()) begin
      bad++; $display("FAIL after_busy_accept got=%h want=%h", obs_main(), exp_main());
    end
  endtask

  task automatic test_stall();
    settle();
    b1 = 1; p1 = 0; t1 = 1; pc1 = 11'h0AB; stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({rv, bz} !== 2'b00 || obs_main() !== exp_main()) begin
        bad++; $display("FAIL stall_hold[%0d] got=%h want=%h", i, obs_main(), exp_main());
      end
    end
    stall = 0;
    tick();
    quiet();
    total++;
    if ({rv, rpc, cnt} !== {1'b1, 11'h0AB, 16'd5} || obs_main() !== exp_main()) begin
      bad++; $display("FAIL stall_release got=%h want=%h", obs_main(), exp_main());
    end
  endtask

  task automatic test_clear_capture();
    settle();
    b1 = 1; p1 = 1; t1 = 0; pc1 = 11'h111; clr = 1;
    tick();
    quiet();
    total++;
    if ({rv, cnt} !== {1'b1, 16'd0} || obs_main() !== exp_main()) begin
      bad++; $display("FAIL clear_with_capture got=%h want=%h", obs_main(), exp_main());
    end
  endtask

  task automatic test_random();
    settle();
    for (int i = 0; i < 400; i++) begin
      b1 = 1'($urandom); b2 = 1'($urandom); p1 = 1'($urandom); p2 = 1'($urandom);
      t1 = 1'($urandom); t2 = 1'($urandom); pc1 = PC_W'($urandom); pc2 = PC_W'($urandom);
      stall = ($urandom_range(0, 3) == 0); clr = ($urandom_range(0, 40) == 0);
      tick();
      total++;
      if (obs_main() !== exp_main() || obs_sat() !== exp_sat()) begin
        bad++; $display("FAIL random[%0d] got=%h/%h want=%h/%h", i, obs_main(), obs_sat(), exp_main(), exp_sat());
      end
    end
    quiet();
  endtask

  task automatic test_saturate();
    settle();
    for (int i = 0; i < 12; i++) begin
      b1 = 1; p1 = 0; t1 = 1; pc1 = PC_W'(i);
      tick();
      quiet();
      repeat (S + 1) tick();
    end
    total++;
    if (s_cnt !== 3'h7 || obs_sat() !== exp_sat()) begin
      bad++; $display("FAIL saturate got=%h want=%h", obs_sat(), exp_sat());
    end
    clr = 1;
    tick();
    clr = 0;
    total++;
    if ({s_cnt, cnt} !== 19'd0) begin
      bad++; $display("FAIL clear_stats got=%0d/%0d want=0/0", s_cnt, cnt);
    end
  endtask

  task automatic test_reset_in_shadow();
    settle();
    b2 = 1; p2 = 0; t2 = 1; pc2 = 11'h2C4;
    tick();
    quiet();
    tick();
    #3 rst = 1;
    #1;
    total++;
    if (obs_main() !== 33'd0 || obs_sat() !== 20'd0) begin
      bad++; $display("FAIL reset_shadow got=%h/%h want=0/0", obs_main(), obs_sat());
    end
    model_reset();
    #2 rst = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({rv, bz} !== 2'b00 || obs_main() !== exp_main()) begin
        bad++; $display("FAIL post_abort[%0d] got=%h want=%h", i, obs_main(), exp_main());
      end
    end
  endtask

  initial begin
    test_reset();
    test_slot1();
    test_both_slots();
    test_slot2_shadow();
    test_stall();
    test_clear_capture();
    test_random();
    test_saturate();
    test_reset_in_shadow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mispredict_recovery_ctrl.md
MISPREDICT_RECOVERY_CTRL -- requirements
Module: mispredict_recovery_ctrl

Interface
REQ-001 The block SHALL have parameter PC_W, default 11, PC width in words.
REQ-002 The block SHALL have parameter SHADOW_CYCLES, default 2, the number of cycles after a redirect during which wrong-path resolutions are ignored; legal range 1-15.
REQ-003 The block SHALL have parameter CNT_W, default 16, the mispredict counter width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-005 Port clk, input, 1 bit: rising-edge clock.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Ports branchM1, branchM2, input, 1 bit each: the slot holds a resolved conditional branch in M.
REQ-008 Ports PredictionM1, PredictionM2, input, 1 bit each: the predicted-taken bit carried with the slot.
REQ-009 Ports branch_taken1, branch_taken2, input, 1 bit each: the actual branch outcome.
REQ-010 Ports CorrectedPC1, CorrectedPC2, input, PC_W bits each: the recovery target per slot from the PC correction unit.
REQ-011 Port stallM, input, 1 bit: the M stage is frozen this cycle.
REQ-012 Port clear_stats, input, 1 bit: synchronous clear of mispredict_count.
REQ-013 Port redirect_valid, output, 1 bit: fetch SHALL load redirect_pc this cycle.
REQ-014 Port redirect_pc, output, PC_W bits: the redirect target.
REQ-015 Ports flushF, flushD, flushE, output, 1 bit each: bubble the named pipeline register.
REQ-016 Port squash_slot2, output, 1 bit: slot 2 of M is discarded (no writeback or store).
REQ-017 Port busy, output, 1 bit: the FSM is not in IDLE.
REQ-018 Port mispredict_count, output, CNT_W bits: the saturating count of accepted mispredicts.

Function
REQ-019 A slot SHALL be mispredicted when mispN = branchMN & (PredictionMN != branch_takenN).
REQ-020 The FSM SHALL have exactly three states: IDLE, REDIRECT and SHADOW.
REQ-021 In IDLE with !stallM and (misp1 | misp2), the FSM SHALL capture the target and move to REDIRECT on the next edge.
- Target is CorrectedPC1 if misp1 is set (slot 1 is older and wins); otherwise CorrectedPC2.
REQ-022 In IDLE, no capture SHALL occur while stallM=1; a held mispredict SHALL be accepted on the first cycle in which stallM=0.
REQ-023 REDIRECT SHALL last exactly one cycle.
- Outputs during REDIRECT: redirect_valid=1, flushF=flushD=flushE=1, redirect_pc=captured target.
- squash_slot2=1 only if slot 1 was the winner.
- This state ignores stallM: flush dominates stall.
REQ-024 REDIRECT SHALL always move to SHADOW, loading a down-counter with SHADOW_CYCLES.
REQ-025 In SHADOW, the counter SHALL decrement each cycle; branch inputs SHALL be ignored; the FSM SHALL return to IDLE on the cycle the counter reaches 0.
- SHADOW therefore lasts exactly SHADOW_CYCLES cycles.
REQ-026 Latency SHALL be one cycle: a mispredict sampled at edge N produces redirect_valid high between edges N and N+1.
REQ-027 All outputs SHALL be registered; redirect_pc SHALL hold its last value outside REDIRECT.
REQ-028 redirect_valid, flushF, flushD, flushE and squash_slot2 SHALL be 0 in IDLE and SHADOW.
REQ-029 busy SHALL be 1 in REDIRECT and SHADOW, and 0 in IDLE.
REQ-030 mispredict_count SHALL increment by 1 on each accepted capture (one per capture even if both slots mispredict) and saturate at all-ones.
REQ-031 clear_stats SHALL zero the counter; if clear_stats coincides with a capture, the result SHALL be 0.
REQ-032 Mispredicts in a cycle that returns SHADOW->IDLE SHALL be ignored; capture is possible from the following cycle.

Reset
REQ-033 On rst=1, asynchronously and regardless of state:
- FSM=IDLE, shadow counter=0, redirect_pc=0, mispredict_count=0.
- All 1-bit outputs = 0.
REQ-034 Reset asserted during REDIRECT or SHADOW SHALL abort recovery; no redirect pulse SHALL follow reset deassertion unless a new mispredict is captured.

Verification
REQ-035 Slot 1 mispredict: branchM1=1, Prediction=0, taken=1, CorrectedPC1=0x1A0 -> next cycle redirect_valid=1, redirect_pc=0x1A0, flushF/D/E=1, squash_slot2=1; busy for 3 cycles; count=1.
REQ-036 Both slots mispredict, CorrectedPC1=0x010, CorrectedPC2=0x020 -> redirect_pc=0x010, squash_slot2=1, count increments by 1.
REQ-037 Slot 2 only mispredicts, CorrectedPC2=0x7FF -> redirect_pc=0x7FF, squash_slot2=0.
- A mispredict presented during the 2 SHADOW cycles produces no pulse.
- A mispredict presented 1 cycle after busy falls is accepted.
REQ-038 Mispredict held with stallM=1 for 3 cycles -> no redirect until stallM falls; redirect_valid is high the cycle after stallM=0.
REQ-039 Counter preloaded to 0xFFFF via 65535 mispredicts (or forced) -> a further mispredict leaves it at 0xFFFF; clear_stats -> 0x0000.
REQ-040 rst pulsed in the first SHADOW cycle -> all outputs 0 immediately, busy=0, count=0, and no later redirect pulse.
